// File: rtl/fwft_fifo_pkg.sv
// Shared constants and width helpers for the parametrised FWFT FIFO.
// Optional error flags are enabled by defining FWFT_FIFO_ERR_FLAGS_EN.
package fwft_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 16;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy counter width, able to hold the value DEPTH.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [ptr_width(DEF_DEPTH)-1:0] def_ptr_t;
    typedef logic [cnt_width(DEF_DEPTH)-1:0] def_cnt_t;

endpackage

// File: rtl/fwft_fifo_param_if.sv
// Producer/consumer bus for the FWFT FIFO; the master drives push/pop, the slave is the FIFO.
// Error flag signals exist only when FWFT_FIFO_ERR_FLAGS_EN is defined.
interface fwft_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = fwft_fifo_pkg::DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = fwft_fifo_pkg::DEF_DEPTH
);
    import fwft_fifo_pkg::*;

    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic                  flush_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [CNT_W-1:0]      count_o;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic                  clr_err_i;
    logic                  overflow_o;
    logic                  underflow_o;
`endif

    modport master (
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        output clr_err_i,
        input  overflow_o, underflow_o,
`endif
        output flush_i, wr_en_i, data_i, rd_en_i,
        input  data_o, full_o, empty_o, almost_full_o, almost_empty_o, count_o
    );

    modport slave (
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        input  clr_err_i,
        output overflow_o, underflow_o,
`endif
        input  flush_i, wr_en_i, data_i, rd_en_i,
        output data_o, full_o, empty_o, almost_full_o, almost_empty_o, count_o
    );

endinterface

// File: rtl/fwft_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fwft_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fwft_fifo_param.sv
// First-word-fall-through FIFO with occupancy count, threshold flags and synchronous flush.
// Define FWFT_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with clr_err_i.
module fwft_fifo_param
    import fwft_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fwft_fifo_param_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ptr_width(DEPTH);
    localparam int unsigned CNT_W  = cnt_width(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    cnt_t r_count;
    logic r_full;
    logic r_empty;
    logic r_almost_full;
    logic r_almost_empty;

    ptr_t w_wr_ptr_nxt;
    ptr_t w_rd_ptr_nxt;
    cnt_t w_count_nxt;
    logic w_push;
    logic w_pop;
    logic w_mem_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push   = bus.wr_en_i && (!r_full || bus.rd_en_i);
    assign w_pop    = bus.rd_en_i && !r_empty;
    assign w_mem_we = w_push && !bus.flush_i && !rst_i;

    fwft_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_mem_we),
        .waddr_i (r_wr_ptr[ADDR_W-1:0]),
        .wdata_i (bus.data_i),
        .raddr_i (r_rd_ptr[ADDR_W-1:0]),
        .rdata_o (w_rdata)
    );

    // Next-state pointers and count; flush returns everything to zero.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (bus.flush_i) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + ptr_t'(1);
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + cnt_t'(1);
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == cnt_t'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= cnt_t'(AF_THRESH));
            r_almost_empty <= (w_count_nxt <= cnt_t'(AE_THRESH));
        end
    end

    assign bus.data_o         = r_empty ? '0 : w_rdata;
    assign bus.full_o         = r_full;
    assign bus.empty_o        = r_empty;
    assign bus.almost_full_o  = r_almost_full;
    assign bus.almost_empty_o = r_almost_empty;
    assign bus.count_o        = r_count;

`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_evt;
    logic w_unf_evt;

    // A read paired with a write on an empty FIFO is not an underflow.
    assign w_ovf_evt = bus.wr_en_i && r_full && !bus.rd_en_i;
    assign w_unf_evt = bus.rd_en_i && r_empty && !bus.wr_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err_i) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;
`endif

endmodule

// File: tb/tb_fwft_fifo_param.sv
// Randomised self-checking bench for fwft_fifo_param against a queue-based reference model.
// Error-flag checks are compiled in when FWFT_FIFO_ERR_FLAGS_EN is defined.
module tb_fwft_fifo_param;
    import fwft_fifo_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned AF = 6;
    localparam int unsigned AE = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    fwft_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

    fwft_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    // {data_o, count_o, full_o, empty_o, almost_full_o, almost_empty_o}
    logic [15:0] status;
    assign status = {bus.data_o, bus.count_o, bus.full_o, bus.empty_o,
                     bus.almost_full_o, bus.almost_empty_o};

    function automatic logic [15:0] exp_status();
        logic [DW-1:0] head;
        int n;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        return {head, 4'(n), n == int'(D), n == 0, n >= int'(AF), n <= int'(AE)};
    endfunction

    // One clock with the given inputs; the model advances by the FIFO rules on the same edge.
    task automatic cycle(input bit wr, input bit rd, input bit fl, input logic [DW-1:0] din,
                         input bit clr = 1'b0);
        bit push;
        bit pop;
        bit ovf_evt;
        bit unf_evt;
        bus.wr_en_i = wr;
        bus.rd_en_i = rd;
        bus.flush_i = fl;
        bus.data_i  = din;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        bus.clr_err_i = clr;
`endif
        @(posedge clk_i);
        ovf_evt = wr && (q.size() == int'(D)) && !rd;
        unf_evt = rd && (q.size() == 0) && !wr;
        if (fl) begin
            q.delete();
        end else begin
            push = wr && ((q.size() < int'(D)) || rd);
            pop  = rd && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(din);
        end
        if (ovf_evt) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (unf_evt) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        #1;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        bus.flush_i = 1'b0;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        bus.clr_err_i = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        bus.wr_en_i = 1'b1;
        bus.rd_en_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.data_i  = 8'hC3;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        bus.clr_err_i = 1'b0;
`endif
        @(posedge clk_i);
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        rst_i       = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (status !== 16'h0005) begin
            errors++;
            $display("FAIL reset_status got %h exp %h", status, 16'h0005);
        end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        checks++;
        if ({bus.overflow_o, bus.underflow_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_err got %b exp 00", {bus.overflow_o, bus.underflow_o});
        end
`endif
    endtask

    task automatic test_fwft_push();
        logic [DW-1:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, vals[i]);
            checks++;
            if (bus.data_o !== 8'h11 || bus.empty_o !== 1'b0 || bus.count_o !== 4'(i + 1)
                || bus.almost_empty_o !== (i < 2)) begin
                errors++;
                $display("FAIL fwft_push step %0d got data %h empty %b count %0d ae %b",
                         i, bus.data_o, bus.empty_o, bus.count_o, bus.almost_empty_o);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < int'(D); i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 1'b0, 8'hAA);
        checks++;
        if (bus.full_o !== 1'b1 || bus.count_o !== 4'd8 || status !== exp_status()) begin
            errors++;
            $display("FAIL overflow_full got %h exp %h", status, exp_status());
        end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got %b exp 1", bus.overflow_o);
        end
`endif
        for (int i = 0; i < int'(D); i++) begin
            checks++;
            if (bus.data_o !== 8'(i)) begin
                errors++;
                $display("FAIL overflow_pop %0d got %h exp %h", i, bus.data_o, 8'(i));
            end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
        checks++;
        if (status !== 16'h0005) begin
            errors++;
            $display("FAIL overflow_drained got %h exp %h", status, 16'h0005);
        end
        // Read on empty: ignored, data_o stays zero
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (status !== 16'h0005) begin
            errors++;
            $display("FAIL empty_read got %h exp %h", status, 16'h0005);
        end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL underflow_flag got %b exp 1", bus.underflow_o);
        end
`endif
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] exp_seq [8];
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};
        do_reset();
        for (int i = 0; i < int'(D); i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        checks++;
        if (bus.count_o !== 4'd8 || bus.full_o !== 1'b1 || bus.data_o !== 8'h01) begin
            errors++;
            $display("FAIL full_rw got count %0d full %b data %h exp 8 1 01",
                     bus.count_o, bus.full_o, bus.data_o);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.data_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL full_rw_pop %0d got %h exp %h", i, bus.data_o, exp_seq[i]);
            end
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_empty_rw();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'h99);
        checks++;
        if (bus.count_o !== 4'd1 || bus.data_o !== 8'h99 || bus.empty_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw got count %0d data %h empty %b exp 1 99 0",
                     bus.count_o, bus.data_o, bus.empty_o);
        end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw_unf got %b exp 0", bus.underflow_o);
        end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        // Push/pop pairs: 20 pushes walk the pointers round the 8-entry array twice
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            checks++;
            if (status !== exp_status()) begin
                errors++;
                $display("FAIL wrap_push %0d got %h exp %h", i, status, exp_status());
            end
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'($urandom));
            checks++;
            if (status !== exp_status()) begin
                errors++;
                $display("FAIL wrap_pop %0d got %h exp %h", i, status, exp_status());
            end
        end
        // Biased phases drive occupancy into full and empty repeatedly
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 60; i++) begin
                bit wr;
                bit rd;
                wr = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 25));
                rd = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 75));
                cycle(wr, rd, 1'b0, 8'($urandom));
                checks++;
                if (status !== exp_status()) begin
                    errors++;
                    $display("FAIL random ph %0d cyc %0d got %h exp %h",
                             ph, i, status, exp_status());
                end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
                checks++;
                if ({bus.overflow_o, bus.underflow_o} !== {m_ovf, m_unf}) begin
                    errors++;
                    $display("FAIL random_err ph %0d cyc %0d got %b exp %b", ph, i,
                             {bus.overflow_o, bus.underflow_o}, {m_ovf, m_unf});
                end
`endif
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < int'(D); i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        cycle(1'b1, 1'b0, 1'b0, 8'hAB);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (bus.count_o !== 4'd5 || bus.data_o !== 8'h43) begin
            errors++;
            $display("FAIL pre_flush got count %0d data %h exp 5 43", bus.count_o, bus.data_o);
        end
        cycle(1'b1, 1'b0, 1'b1, 8'hEE);
        checks++;
        if (status !== 16'h0005) begin
            errors++;
            $display("FAIL flush got %h exp %h", status, 16'h0005);
        end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_ovf got %b exp 1", bus.overflow_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_err got %b exp 0", bus.overflow_o);
        end
`endif
        cycle(1'b1, 1'b0, 1'b0, 8'h42);
        checks++;
        if (status !== exp_status() || bus.data_o !== 8'h42 || bus.count_o !== 4'd1) begin
            errors++;
            $display("FAIL post_flush_push got %h exp %h", status, exp_status());
        end
    endtask

    initial begin
        test_reset();
        test_fwft_push();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwft_fifo_param.md
Name: fwft_fifo_param

Overview:
- Parametrised next-generation first-word-fall-through FIFO: data width, depth and almost-full/almost-empty thresholds are set per instance.
- Adds an occupancy count, threshold flags and a synchronous flush.
- Sits between producer/consumer pipelines in one clock domain. The head word is always presented on data_o while not empty; rd_en_i acts as a pop/acknowledge.

Parameters:
- DATA_WIDTH, 8, bits per word.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- AF_THRESH, DEPTH-2, almost_full_o asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty_o asserted when count <= AE_THRESH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous clear of contents; pointers and count return to zero.
- wr_en_i  in  1  push request.
- data_i  in  DATA_WIDTH  push data.
- rd_en_i  in  1  pop request (acknowledges the current head).
- data_o  out  DATA_WIDTH  head word; zero while empty.
- full_o  out  1  FIFO holds DEPTH words.
- empty_o  out  1  FIFO holds 0 words.
- almost_full_o  out  1  count >= AF_THRESH.
- almost_empty_o  out  1  count <= AE_THRESH.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On a rising edge with rst_i=1:
  - write and read pointers are 0 and count_o=0;
  - empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0;
  - data_o=0. Storage array contents are not reset.
- rst_i has priority over flush_i, which has priority over any push or pop in the same cycle.
- Pointers are $clog2(DEPTH)+1 bits wide with a wrap bit; the address is the low bits.
  - full when addresses are equal and wrap bits differ; empty when both are equal.
  - Wrap-around from DEPTH-1 to 0 is seamless.
- Push is accepted when wr_en_i && (!full_o || rd_en_i). Pop is accepted when rd_en_i && !empty_o.
- Full with simultaneous wr+rd: both are accepted; count is unchanged; full_o stays 1.
- Empty with simultaneous wr+rd: the read is ignored and the write is accepted; count becomes 1.
- Write when full without rd_en_i: dropped, no state change. Read when empty: ignored, data_o stays 0.
- Count update per edge: count_o +1 on push only, -1 on pop only, unchanged on both or neither.
- All status flags are registered and decoded from the next-state count, so they are valid in the same cycle as count_o.
- FWFT latency: a word pushed into an empty FIFO at edge N appears on data_o with empty_o=0 after edge N, i.e. one cycle. There is no read latency.
- Pop at edge N: data_o shows the next word after edge N, or 0 with empty_o=1 if that was the last word.
- data_o is combinational from the storage array at the read address, gated to 0 while empty_o.
- Flush mid-operation: after the edge the FIFO behaves exactly as after reset, except the optional error flags are kept.

Optional Feature:
- Macro FWFT_FIFO_ERR_FLAGS_EN.
- When defined:
  - adds ports overflow_o (out, 1) and underflow_o (out, 1), plus clr_err_i (in, 1);
  - overflow_o sets sticky on a dropped write; underflow_o sets sticky on an ignored read;
  - both clear on rst_i or clr_err_i; a set event in the same cycle as clr_err_i wins.
- When undefined: these ports and registers do not exist, and drop/ignore behaviour is otherwise identical.

Decomposition:
- fwft_fifo_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - a ptr_t-style typedef helper;
  - a count-width function equivalent to $clog2(DEPTH+1).
- One sub-module, fwft_fifo_mem: a simple dual-port array with one synchronous write port and one asynchronous read port, parametrised by DATA_WIDTH and DEPTH.
- Control logic (pointers, count, flags) stays in the top module.

Test Plan:
- DEPTH=8, DATA_WIDTH=8, AF=6, AE=2:
  - Reset, then push 0x11,0x22,0x33 on consecutive cycles -> after the first edge empty_o=0, data_o=0x11; count_o=3; almost_empty_o=0 only after count reaches 3.
  - Push 8 words 0x00..0x07, then wr_en_i with 0xAA and no read -> full_o=1, count_o=8, 0xAA dropped (overflow_o=1 if EN); 8 pops return 0x00..0x07 in order; empty_o=1, data_o=0.
  - Full FIFO with wr+rd in the same cycle (data 0x55) -> count_o stays 8, head advances, 0x55 is returned last.
  - Empty FIFO with wr(0x99)+rd in the same cycle -> count_o=1, data_o=0x99 next cycle, no underflow change.
  - Wrap test: 20 push/pop pairs interleaved with random data -> scoreboard matches order; pointers wrap twice; flags are correct at every boundary.
  - Push 5 words, assert flush_i together with wr_en_i -> next cycle count_o=0, empty_o=1, data_o=0; a sticky overflow_o survives the flush and clears on clr_err_i.
